// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-access bridge.
// Each transaction takes IDLE -> ACCESS -> DONE, acking the winner in DONE.
module bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic [31:0] m0_rd,
  output logic [31:0] m1_rd,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        last;
  logic        lat_we;
  logic        lat_ok;
  logic        win;
  logic [31:0] sel_addr;
  logic [31:0] sel_wd;
  logic        sel_we;
  logic        sel_ok;
  logic [31:0] cap;

  always_comb begin
    win = 1'b0;
    case ({m0_req, m1_req})
      2'b11:   win = ~last;
      2'b01:   win = 1'b1;
      default: win = 1'b0;
    endcase
    sel_addr = win ? m1_addr : m0_addr;
    sel_wd   = win ? m1_wd   : m0_wd;
    sel_we   = win ? m1_we   : m0_we;
  end

  // Two 12-byte windows at 0x7F00 and 0x7F10; word slot 3 of each is a hole.
  assign sel_ok = (sel_addr[1:0] == 2'b00)
               && (sel_addr[31:5] == 27'h3F8)
               && (sel_addr[3:2] != 2'b11);

  assign cap  = (lat_ok && !lat_we) ? PrRD : 32'h0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      lat_we <= 1'b0;
      lat_ok <= 1'b0;
      PrAddr <= 32'h0;
      PrWD   <= 32'h0;
      PrWE   <= 1'b0;
      m0_rd  <= 32'h0;
      m1_rd  <= 32'h0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state  <= ACCESS;
            last   <= win;
            lat_we <= sel_we;
            lat_ok <= sel_ok;
            PrAddr <= sel_addr;
            PrWD   <= sel_wd;
            PrWE   <= sel_we & sel_ok;
          end
        end
        ACCESS: begin
          state  <= DONE;
          PrAddr <= 32'h0;
          PrWD   <= 32'h0;
          PrWE   <= 1'b0;
          if (last) begin
            m1_ack <= 1'b1;
            m1_err <= ~lat_ok;
            m1_rd  <= cap;
          end else begin
            m0_ack <= 1'b1;
            m0_err <= ~lat_ok;
            m0_rd  <= cap;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wd = '0, m1_wd = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_rd, m1_rd, PrAddr, PrWD;
  logic [31:0] PrRD = '0;
  logic        m0_ack, m1_ack, m0_err, m1_err, PrWE, busy;

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_rd(m0_rd), .m1_rd(m1_rd),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE),
    .PrRD(PrRD), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a transaction is pending for `left` more cycles after its grant.
  int          left = 0;
  int          last = 1;
  int          who = 0;
  logic [31:0] t_addr, t_wd;
  bit          t_we, t_ok;
  logic [31:0] e_rd [2];
  bit          e_ack [2];
  bit          e_err [2];
  logic [31:0] e_addr, e_wd;
  bit          e_we, e_busy;

  function automatic bit addr_ok(input logic [31:0] a);
    bit in_win;
    in_win = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    return in_win && (a % 4 == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
    e_addr = 0; e_wd = 0; e_we = 0;
    if (reset) begin
      left = 0; last = 1; e_rd[0] = 0; e_rd[1] = 0; e_busy = 0;
    end else if (left == 0) begin
      e_busy = 0;
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) who = 1 - last;
        else who = m1_req ? 1 : 0;
        last = who;
        t_addr = who ? m1_addr : m0_addr;
        t_wd = who ? m1_wd : m0_wd;
        t_we = who ? m1_we : m0_we;
        t_ok = addr_ok(t_addr);
        e_addr = t_addr; e_wd = t_wd; e_we = t_we && t_ok;
        e_busy = 1; left = 2;
      end
    end else if (left == 2) begin
      e_ack[who] = 1;
      e_err[who] = !t_ok;
      e_rd[who] = (t_ok && !t_we) ? PrRD : 32'h0;
      e_busy = 1; left = 1;
    end else begin
      e_busy = 0; left = 0;
    end
  endtask

  task automatic compare();
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_rd", m0_rd, e_rd[0]);
    chk("m1_rd", m1_rd, e_rd[1]);
    chk("PrAddr", PrAddr, e_addr);
    chk("PrWD", PrWD, e_wd);
    chk("PrWE", PrWE, e_we);
    chk("busy", busy, e_busy);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_reqs();
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    int nwe;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_m0_rd", m0_rd, 0);
    chk("rst_PrWE", PrWE, 0);
    reset = 0;

    // M0 read of a valid register
    m0_req = 1; m0_addr = 32'h7F04; m0_we = 0; PrRD = 32'h1234;
    cyc();
    chk("rd_PrAddr", PrAddr, 32'h7F04);
    chk("rd_PrWE", PrWE, 0);
    m0_req = 0; m0_addr = 32'h5555;
    cyc();
    chk("rd_ack", m0_ack, 1);
    chk("rd_data", m0_rd, 32'h1234);
    chk("rd_err", m0_err, 0);
    cyc();
    chk("rd_hold", m0_rd, 32'h1234);
    chk("rd_ack_off", m0_ack, 0);

    // M1 write: PrWE high exactly one cycle
    m1_req = 1; m1_addr = 32'h7F10; m1_wd = 32'hDEADBEEF; m1_we = 1;
    nwe = 0;
    cyc();
    chk("wr_PrAddr", PrAddr, 32'h7F10);
    chk("wr_PrWD", PrWD, 32'hDEADBEEF);
    nwe += PrWE;
    m1_req = 0;
    cyc();
    nwe += PrWE;
    chk("wr_ack", m1_ack, 1);
    chk("wr_err", m1_err, 0);
    chk("wr_m0_ack", m0_ack, 0);
    cyc();
    nwe += PrWE;
    chk("wr_we_cycles", nwe, 1);

    // Round-robin from reset: acks at cycles 2,5,8,11
    reset = 1; m0_req = 1; m1_req = 1;
    m0_addr = 32'h7F00; m1_addr = 32'h7F08; m0_we = 0; m1_we = 0;
    cyc();
    reset = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("rr_m0_ack_c%0d", k), m0_ack, (k == 2 || k == 8) ? 1 : 0);
      chk($sformatf("rr_m1_ack_c%0d", k), m1_ack, (k == 5 || k == 11) ? 1 : 0);
    end
    idle_reqs();
    cyc(); cyc(); cyc();

    // Decode errors never reach the bridge
    m0_req = 1; m0_we = 1; m0_wd = 32'hCAFEF00D; m0_addr = 32'h7F0C;
    cyc();
    chk("de1_PrWE", PrWE, 0);
    m0_req = 0;
    cyc();
    chk("de1_ack", m0_ack, 1);
    chk("de1_err", m0_err, 1);
    chk("de1_rd", m0_rd, 0);
    cyc();
    m0_req = 1; m0_addr = 32'h7F02;
    cyc();
    chk("de2_PrWE", PrWE, 0);
    m0_req = 0;
    cyc();
    chk("de2_ack", m0_ack, 1);
    chk("de2_err", m0_err, 1);
    chk("de2_rd", m0_rd, 0);
    chk("de2_PrWE_done", PrWE, 0);
    cyc();

    // Reset during ACCESS aborts the write
    m0_req = 1; m0_addr = 32'h7F08; m0_we = 1;
    cyc();
    chk("ab_PrWE_access", PrWE, 1);
    reset = 1; m0_req = 0;
    cyc();
    chk("ab_PrWE", PrWE, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ack", m0_ack, 0);
    reset = 0;
    cyc();
    chk("ab_no_ack", m0_ack, 0);
    m0_req = 1; m1_req = 1; m0_we = 0; m1_addr = 32'h7F14;
    cyc();
    chk("ab_tie_m0", PrAddr, 32'h7F08);
    idle_reqs();
    cyc(); cyc();

    // M1 drops req and changes addr during ACCESS
    m1_req = 1; m1_addr = 32'h7F14; m1_we = 0; PrRD = 32'hABCD;
    cyc();
    chk("late_PrAddr", PrAddr, 32'h7F14);
    m1_req = 0; m1_addr = 32'h7F00; m1_we = 1;
    cyc();
    chk("late_ack", m1_ack, 1);
    chk("late_rd", m1_rd, 32'hABCD);
    cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      m0_req = ($urandom_range(0, 2) != 0);
      m1_req = ($urandom_range(0, 2) != 0);
      m0_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h7EF8 + $urandom_range(0, 44);
      m1_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h7EF8 + $urandom_range(0, 44);
      m0_wd = $urandom; m1_wd = $urandom;
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      PrRD = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
